job_disable_sched: RTL and testbench
====================================

Name: job_disable_sched

Overview:
- Round-robin scheduler that shares one timed worker slot among NREQ requesters.
- Each granted job runs for a per-requester cycle count, then completes.
- A global abort input terminates the active job immediately, the hardware analogue of disabling a named block mid-execution.
- Sits between the requesting processes and the shared worker; drives the worker's one-hot grant and reports completion or abort.

Parameters:
- NREQ, 4, number of requesters (2..16).
- CNTW, 8, width of each job-length field and of the internal down-counter.
- IDW, 2, width of the id outputs; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  NREQ  per-requester job request, level; sampled only in IDLE.
- len  input  NREQ*CNTW  job length in cycles; requester i uses len[i*CNTW +: CNTW]; sampled at grant.
- abort  input  1  terminate the active job; ignored outside RUN.
- grant  output  NREQ  one-hot; asserted for the whole of RUN.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on abort.
- cur_id  output  IDW  index of the granted or last-finished requester.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, grant=0, busy=0, done=0, aborted=0, cur_id=0.
  - Round-robin pointer=NREQ-1, so requester 0 has first priority.
  - Counter=0.
  - Reset asserted mid-RUN drops grant at once; no done or aborted pulse is produced.
- States: IDLE, RUN, FIN, KILL.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward (with wrap) from pointer+1.
  - Next cycle: state=RUN, grant=onehot(winner), cur_id=winner, counter=len[winner], pointer=winner.
  - len==0 is treated as 1.
  - No req set: stay in IDLE with outputs quiet.
- RUN:
  - Counter decrements by 1 each cycle; grant stays stable.
  - abort=1: next state KILL, regardless of counter value.
  - abort=0 and counter==1: next state FIN.
  - Deasserting req during RUN has no effect; the job runs to completion or abort.
- FIN: grant=0, busy=0, done=1 for exactly one cycle, cur_id held; then IDLE.
- KILL: grant=0, busy=0, aborted=1 for exactly one cycle, cur_id held; then IDLE.
- Timing: a job of length L granted from IDLE at edge t has grant high for L cycles, then a done pulse. Back-to-back jobs therefore have a 2-cycle gap (FIN + IDLE arbitration).
- Simultaneous abort and counter==1: abort wins; aborted pulses and done does not.
- abort in IDLE, FIN or KILL: ignored with no state effect. It is not latched.
- done and aborted are never high in the same cycle; grant is never multi-hot.

Optional Feature:
- Macro: JOB_DISABLE_SCHED_RETRY_EN.
- Defined: after KILL, the pointer is restored to its value before the aborted grant. If the aborted requester still holds req, it is re-granted first in the next IDLE arbitration.
- Undefined: the pointer stays at the aborted requester, so the next arbitration starts at the following index (normal round-robin fairness).

Test Plan:
- Reset, then req=4'b0001, len0=3: grant=0001 for 3 cycles, then done=1 with cur_id=0, then IDLE. No aborted pulse.
- req=4'b1111 held, all len=1: grants rotate 0001→0010→0100→1000→0001, with a done pulse after each.
- req=4'b0010, len1=10, abort pulsed on the 4th RUN cycle: grant drops next cycle, aborted=1 for one cycle, cur_id=1, done never asserts.
- len0=2, abort asserted on the last RUN cycle (counter==1): aborted=1 and done=0.
- Two requesters, req=4'b0011, abort requester 0's job:
  - Macro undefined: next grant=0010.
  - Macro defined: next grant=0001.
- rst_n driven low mid-RUN of a len=20 job: all outputs 0 asynchronously. After release with req=0, the block stays IDLE with no done or aborted pulse. With len0=0 it then runs for exactly 1 cycle.

Source files
------------

// File: rtl/job_disable_sched.sv
// Round-robin scheduler for one timed worker slot; a running job ends on its own count or on abort.
// Optional macro JOB_DISABLE_SCHED_RETRY_EN: an aborted requester gets first pick at the next arbitration.
module job_disable_sched #(
    parameter int NREQ = 4,
    parameter int CNTW = 8,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CNTW-1:0] len,
    input  logic                 abort,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [IDW-1:0]       cur_id
);

    typedef enum logic [1:0] {IDLE, RUN, FIN, KILL} state_t;

    state_t            state_q;
    logic [NREQ-1:0]   grant_q;
    logic              busy_q;
    logic              done_q;
    logic              aborted_q;
    logic [IDW-1:0]    cur_id_q;
    logic [IDW-1:0]    ptr_q;
    logic [CNTW-1:0]   cnt_q;
`ifdef JOB_DISABLE_SCHED_RETRY_EN
    logic [IDW-1:0]    prev_ptr_q;
`endif

    logic              found;
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    idx_w;
    logic [CNTW-1:0]   len_a [NREQ];
    logic [CNTW-1:0]   win_len;
    logic [CNTW-1:0]   load_d;

    // First requester at or after ptr+1, wrapping around.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_w = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = IDW'(idx);
            if (!found && req[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) len_a[i] = len[i*CNTW +: CNTW];
        win_len = len_a[win];
        load_d  = (win_len == '0) ? CNTW'(1) : win_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            cur_id_q   <= '0;
            ptr_q      <= IDW'(NREQ-1);
            cnt_q      <= '0;
`ifdef JOB_DISABLE_SCHED_RETRY_EN
            prev_ptr_q <= IDW'(NREQ-1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                    if (found) begin
                        state_q  <= RUN;
                        grant_q  <= NREQ'(1) << win;
                        busy_q   <= 1'b1;
                        cur_id_q <= win;
                        cnt_q    <= load_d;
                        ptr_q    <= win;
`ifdef JOB_DISABLE_SCHED_RETRY_EN
                        prev_ptr_q <= ptr_q;
`endif
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CNTW'(1);
                    // Abort takes priority over a job finishing in the same cycle.
                    if (abort) begin
                        state_q   <= KILL;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
`ifdef JOB_DISABLE_SCHED_RETRY_EN
                        ptr_q     <= prev_ptr_q;
`endif
                    end else if (cnt_q == CNTW'(1)) begin
                        state_q <= FIN;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN, KILL: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign cur_id  = cur_id_q;

endmodule

// File: tb/tb_job_disable_sched.sv
// Directed and random checks of job_disable_sched against a job-level reference model.
module tb_job_disable_sched;
    localparam int NREQ = 4;
    localparam int CNTW = 8;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*CNTW-1:0] len;
    logic                 abort;
    logic [NREQ-1:0]      grant;
    logic                 busy, done, aborted;
    logic [IDW-1:0]       cur_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: is a job active, how many cycles remain, who owns it, pending pulses.
    bit m_act, m_done, m_abt;
    int m_rem, m_owner, m_ptr, m_prev;

    job_disable_sched #(.NREQ(NREQ), .CNTW(CNTW), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .len(len), .abort(abort),
        .grant(grant), .busy(busy), .done(done), .aborted(aborted), .cur_id(cur_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int lenof(input int i);
        logic [NREQ*CNTW-1:0] t;
        int v;
        t = len >> (i*CNTW);
        v = int'(t[CNTW-1:0]);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic set_len(input int i, input int v);
        logic [NREQ*CNTW-1:0] m;
        m   = (NREQ*CNTW)'({CNTW{1'b1}});
        len = (len & ~(m << (i*CNTW))) | ((NREQ*CNTW)'(CNTW'(v)) << (i*CNTW));
    endtask

    task automatic model_reset();
        m_act = 0; m_done = 0; m_abt = 0;
        m_rem = 0; m_owner = 0; m_ptr = NREQ-1; m_prev = NREQ-1;
    endtask

    task automatic model_next();
        if (m_done || m_abt) begin
            m_done = 0; m_abt = 0;
        end else if (m_act) begin
            if (abort) begin
                m_act = 0; m_abt = 1;
`ifdef JOB_DISABLE_SCHED_RETRY_EN
                m_ptr = m_prev;
`endif
            end else if (m_rem == 1) begin
                m_act = 0; m_done = 1;
            end else begin
                m_rem--;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int w;
                w = (m_ptr + k) % NREQ;
                if (req[w]) begin
                    m_prev = m_ptr; m_ptr = w; m_owner = w;
                    m_act = 1; m_rem = lenof(w);
                    break;
                end
            end
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".grant"},   32'(grant),   m_act ? (32'd1 << m_owner) : 32'd0);
        chk({tag, ".busy"},    32'(busy),    32'(m_act));
        chk({tag, ".done"},    32'(done),    32'(m_done));
        chk({tag, ".aborted"}, 32'(aborted), 32'(m_abt));
        chk({tag, ".cur_id"},  32'(cur_id),  32'(m_owner));
        chk({tag, ".onehot"},  32'($countones(grant) <= 1), 32'd1);
    endtask

    task automatic step(input string tag);
        model_next();
        @(posedge clk);
        #1;
        cmp_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; abort = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; len = '0; abort = 1'b0;
        model_reset();
        #12;
        cmp_all("reset");

        // Single job of length 3.
        do_reset();
        req = 4'b0001; set_len(0, 3);
        step("j1.g");
        req = '0;
        step("j1.r2"); step("j1.r3");
        step("j1.fin");
        chk("j1.done", 32'(done), 32'd1);
        step("j1.idle");

        // All requesting, length 1: strict rotation.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        for (int j = 0; j < 8; j++) begin
            step("rot.g");
            chk("rot.grant", 32'(grant), 32'd1 << (j % NREQ));
            step("rot.fin");
            chk("rot.done", 32'(done), 32'd1);
            step("rot.idle");
        end

        // Abort on the 4th RUN cycle of a length-10 job.
        do_reset();
        req = 4'b0010; set_len(1, 10);
        step("ab.g"); step("ab.r2"); step("ab.r3"); step("ab.r4");
        abort = 1'b1;
        step("ab.kill");
        abort = 1'b0; req = '0;
        chk("ab.aborted", 32'(aborted), 32'd1);
        chk("ab.cur_id", 32'(cur_id), 32'd1);
        step("ab.idle"); step("ab.idle2");

        // Abort coinciding with the final count.
        do_reset();
        req = 4'b0001; set_len(0, 2);
        step("last.g"); step("last.r2");
        abort = 1'b1;
        step("last.kill");
        abort = 1'b0; req = '0;
        chk("last.aborted", 32'(aborted), 32'd1);
        chk("last.done", 32'(done), 32'd0);
        step("last.idle");

        // Which requester follows an aborted one.
        do_reset();
        req = 4'b0011; set_len(0, 5); set_len(1, 2);
        step("rt.g0");
        abort = 1'b1;
        step("rt.kill");
        abort = 1'b0;
        step("rt.idle");
        step("rt.g1");
`ifdef JOB_DISABLE_SCHED_RETRY_EN
        chk("rt.next", 32'(grant), 32'd1);
`else
        chk("rt.next", 32'(grant), 32'd2);
`endif
        req = '0;
        step("rt.r2"); step("rt.fin");

        // Asynchronous reset in the middle of a long job.
        do_reset();
        req = 4'b0001; set_len(0, 20);
        step("mr.g"); step("mr.r2"); step("mr.r3");
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all("mr.async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("mr.q1"); step("mr.q2"); step("mr.q3");
        set_len(0, 0); req = 4'b0001;
        step("mr.z.g");
        req = '0;
        step("mr.z.fin");
        chk("mr.z.done", 32'(done), 32'd1);
        step("mr.z.idle");

        // Random traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) set_len(i, $urandom_range(0, 4));
            abort = ($urandom_range(0, 7) == 0);
            step("rnd");
        end
        abort = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
